// File: rtl/etcpu_boot_loader.sv
// Boot loader for the etcpu core: receives a length-prefixed, XOR-checksummed program
// image as a byte stream, writes it into instruction memory and releases the core on success.
module etcpu_boot_loader #(
    parameter int IMEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_vld,
    input  logic [7:0]  rx_dat,
    output logic        rx_rdy,
    input  logic        boot_req,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdat,
    output logic        core_rst_n,
    output logic        boot_done,
    output logic        boot_err
);

    localparam logic [2:0] S_LEN0 = 3'd0;
    localparam logic [2:0] S_LEN1 = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [16:0] MAX_LEN = 17'(2 ** IMEM_AW);

    logic [2:0]         state;
    logic [15:0]        len;
    logic [1:0]         byte_cnt;
    logic [IMEM_AW:0]   word_idx;
    logic [7:0]         csum;
    logic [31:0]        word_buf;
    logic               xfer;
    logic [31:0]        next_word;
    logic [16:0]        len_full;

    assign rx_rdy    = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
    assign xfer      = rx_vld && rx_rdy;
    // Bytes enter at the top and shift down, so the first byte of a word ends in [7:0].
    assign next_word = {rx_dat, word_buf[31:8]};
    assign len_full  = {1'b0, rx_dat, len[7:0]};

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LEN0;
            len        <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            csum       <= '0;
            word_buf   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdat  <= '0;
            core_rst_n <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN0: begin
                    if (xfer) begin
                        len[7:0] <= rx_dat;
                        state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len[15:8] <= rx_dat;
                        if (len_full > MAX_LEN) begin
                            state    <= S_ERR;
                            boot_err <= 1'b1;
                        end else if (len_full == 17'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_buf <= next_word;
                        csum     <= csum ^ rx_dat;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_wdat <= next_word;
                            imem_addr <= 32'({word_idx, 2'b00});
                            word_idx  <= word_idx + 1'b1;
                            if (16'(word_idx) == len - 16'd1)
                                state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (rx_dat == csum) begin
                            state      <= S_DONE;
                            core_rst_n <= 1'b1;
                            boot_done  <= 1'b1;
                        end else begin
                            state    <= S_ERR;
                            boot_err <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (boot_req) begin
                        state      <= S_LEN0;
                        core_rst_n <= 1'b0;
                        boot_done  <= 1'b0;
                        boot_err   <= 1'b0;
                        len        <= '0;
                        byte_cnt   <= '0;
                        word_idx   <= '0;
                        csum       <= '0;
                    end
                end
                default: state <= S_LEN0;
            endcase
        end
    end

endmodule
